// File: rtl/game_sequencer_if.sv
// Signal bundle between the game flow controller and the surrounding board
// logic (choose-player, throw, HP and wind/speed setup).
// The master drives the player and throw status and consumes the phase outputs.
// The slave is the sequencer itself.
interface game_sequencer_if;
    logic       player1_ready;
    logic       player2_ready;
    logic       current_player;
    logic       throw_flag;
    logic       in_throw_flag;
    logic       end_throw;
    logic [6:0] hp_player1;
    logic [6:0] hp_player2;
    logic       restart;
    logic [2:0] state;
    logic [2:0] turn;
    logic       turn_pulse;
    logic       throw_enable;
    logic       game_over;
    logic [1:0] winner;
    logic       timeout_pulse;

    modport master (
        output player1_ready, player2_ready, current_player, throw_flag,
               in_throw_flag, end_throw, hp_player1, hp_player2, restart,
        input  state, turn, turn_pulse, throw_enable, game_over, winner,
               timeout_pulse
    );

    modport slave (
        input  player1_ready, player2_ready, current_player, throw_flag,
               in_throw_flag, end_throw, hp_player1, hp_player2, restart,
        output state, turn, turn_pulse, throw_enable, game_over, winner,
               timeout_pulse
    );
endinterface

// File: rtl/game_sequencer.sv
// Turn and phase controller for the two-board cat-and-dog throwing game.
// Phases: IDLE -> AIM -> FLIGHT -> SETTLE -> CHECK -> AIM / OVER.
// Optional aiming-window timeout: define GAME_SEQUENCER_AIM_TIMEOUT_EN.
// Control inputs are sampled into registers first; the FSM acts on the
// sampled values one edge later, and every output is a register.
module game_sequencer #(
    parameter int unsigned SETTLE_CYCLES      = 4,
    parameter int unsigned AIM_TIMEOUT_CYCLES = 600_000_000
) (
    input  logic             clk60MHz,
    input  logic             rst,
    game_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AIM    = 3'd1,
        S_FLIGHT = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t     st;
    logic [2:0] turn_r;
    logic       turn_pulse_r;
    logic       throw_en_r;
    logic       game_over_r;
    logic [1:0] winner_r;
    logic [7:0] settle_cnt;

    logic       ready_r;
    logic       end_r;
    logic       restart_r;
    logic       throw_r;
    logic       throw_prev;
    logic       in_throw_r;
    logic       in_throw_prev;

    logic       local_rise;
    logic       remote_rise;
    logic       accepted;
    logic [2:0] turn_inc;
    logic       aim_expired;

    // Edge detection and acceptance of the throw belonging to the active side
    always_comb begin
        local_rise  = throw_r & ~throw_prev;
        remote_rise = in_throw_r & ~in_throw_prev;
        accepted    = (turn_r[0] == bus.current_player) ? local_rise : remote_rise;
        turn_inc    = turn_r + 3'd1;
    end

    // Input sampling and previous-value registers for edge detection
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            ready_r       <= 1'b0;
            end_r         <= 1'b0;
            restart_r     <= 1'b0;
            throw_r       <= 1'b0;
            throw_prev    <= 1'b0;
            in_throw_r    <= 1'b0;
            in_throw_prev <= 1'b0;
        end else begin
            ready_r       <= bus.player1_ready & bus.player2_ready;
            end_r         <= bus.end_throw;
            restart_r     <= bus.restart;
            throw_r       <= bus.throw_flag;
            throw_prev    <= throw_r;
            in_throw_r    <= bus.in_throw_flag;
            in_throw_prev <= in_throw_r;
        end
    end

`ifdef GAME_SEQUENCER_AIM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(AIM_TIMEOUT_CYCLES + 1);
    logic [TW-1:0] aim_cnt;
    logic          timeout_pulse_r;

    assign aim_expired = (aim_cnt == TW'(AIM_TIMEOUT_CYCLES - 1));

    // Aiming-window counter: zero outside AIM, restarts after a forfeit
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            aim_cnt <= '0;
        end else if (st != S_AIM || accepted || aim_expired) begin
            aim_cnt <= '0;
        end else begin
            aim_cnt <= aim_cnt + 1'b1;
        end
    end

    assign bus.timeout_pulse = timeout_pulse_r;
`else
    assign aim_expired       = 1'b0;
    assign bus.timeout_pulse = 1'b0;
`endif

    // Game-flow FSM with registered outputs
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            st           <= S_IDLE;
            turn_r       <= '0;
            turn_pulse_r <= 1'b0;
            throw_en_r   <= 1'b0;
            game_over_r  <= 1'b0;
            winner_r     <= '0;
            settle_cnt   <= '0;
`ifdef GAME_SEQUENCER_AIM_TIMEOUT_EN
            timeout_pulse_r <= 1'b0;
`endif
        end else begin
            turn_pulse_r <= 1'b0;
`ifdef GAME_SEQUENCER_AIM_TIMEOUT_EN
            timeout_pulse_r <= 1'b0;
`endif
            case (st)
                S_IDLE: begin
                    if (ready_r) begin
                        st         <= S_AIM;
                        throw_en_r <= (turn_r[0] == bus.current_player);
                    end
                end
                S_AIM: begin
                    // A throw arriving on the timeout cycle takes priority
                    if (accepted) begin
                        st         <= S_FLIGHT;
                        throw_en_r <= 1'b0;
                    end else if (aim_expired) begin
                        turn_r       <= turn_inc;
                        turn_pulse_r <= 1'b1;
`ifdef GAME_SEQUENCER_AIM_TIMEOUT_EN
                        timeout_pulse_r <= 1'b1;
`endif
                        throw_en_r   <= (turn_inc[0] == bus.current_player);
                    end else begin
                        throw_en_r <= (turn_r[0] == bus.current_player);
                    end
                end
                S_FLIGHT: begin
                    throw_en_r <= 1'b0;
                    if (end_r) begin
                        st         <= S_SETTLE;
                        settle_cnt <= 8'(SETTLE_CYCLES - 1);
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        st <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                S_CHECK: begin
                    if (bus.hp_player1 == '0 && bus.hp_player2 == '0) begin
                        winner_r    <= 2'b11;
                        game_over_r <= 1'b1;
                        st          <= S_OVER;
                    end else if (bus.hp_player1 == '0) begin
                        winner_r    <= 2'b10;
                        game_over_r <= 1'b1;
                        st          <= S_OVER;
                    end else if (bus.hp_player2 == '0) begin
                        winner_r    <= 2'b01;
                        game_over_r <= 1'b1;
                        st          <= S_OVER;
                    end else begin
                        turn_r       <= turn_inc;
                        turn_pulse_r <= 1'b1;
                        throw_en_r   <= (turn_inc[0] == bus.current_player);
                        st           <= S_AIM;
                    end
                end
                S_OVER: begin
                    if (restart_r) begin
                        st          <= S_IDLE;
                        turn_r      <= '0;
                        winner_r    <= '0;
                        game_over_r <= 1'b0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign bus.state        = st;
    assign bus.turn         = turn_r;
    assign bus.turn_pulse   = turn_pulse_r;
    assign bus.throw_enable = throw_en_r;
    assign bus.game_over    = game_over_r;
    assign bus.winner       = winner_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: scenario tasks with a scoreboard queue of
// expected CHECK outcomes, pushed when a landing is driven and popped when
// the outcome appears.
module tb_game_sequencer;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_sequencer_if bif ();

    game_sequencer #(
        .SETTLE_CYCLES      (S),
        .AIM_TIMEOUT_CYCLES (16)
    ) dut (
        .clk60MHz (clk),
        .rst      (rst),
        .bus      (bif)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] turn;
        logic [1:0] winner;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] m_turn;
    int unsigned passed = 0;
    int unsigned total  = 0;

    task tick();
        @(posedge clk);
        #1;
    endtask

    task drive_flag(input logic v);
        if (m_turn[0] == bif.current_player) bif.throw_flag = v;
        else bif.in_throw_flag = v;
    endtask

    task test_reset(input logic cp);
        bif.player1_ready  = 1'b0;
        bif.player2_ready  = 1'b0;
        bif.current_player = cp;
        bif.throw_flag     = 1'b0;
        bif.in_throw_flag  = 1'b0;
        bif.end_throw      = 1'b0;
        bif.restart        = 1'b0;
        bif.hp_player1     = 7'd50;
        bif.hp_player2     = 7'd50;
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({bif.state, bif.turn, bif.turn_pulse, bif.throw_enable, bif.game_over,
             bif.winner, bif.timeout_pulse} !== 13'd0)
            $display("FAIL reset_outputs: got state=%0d turn=%0d te=%0d go=%0d win=%0d want all 0",
                     bif.state, bif.turn, bif.throw_enable, bif.game_over, bif.winner);
        else passed++;
        rst = 1'b0;
        bif.player1_ready = 1'b1;
        tick();
        total++;
        if (bif.state !== 3'd0) $display("FAIL one_ready_idle: got %0d want 0", bif.state);
        else passed++;
        bif.player2_ready = 1'b1;
        tick();
        total++;
        if (bif.state !== 3'd0) $display("FAIL ready_sample_edge: got %0d want 0", bif.state);
        else passed++;
        tick();
        total++;
        if (bif.state !== 3'd1 || bif.turn !== 3'd0 || bif.throw_enable !== ~cp)
            $display("FAIL idle_to_aim: got state=%0d turn=%0d te=%0d want 1 0 %0d",
                     bif.state, bif.turn, bif.throw_enable, ~cp);
        else passed++;
        m_turn = 3'd0;
    endtask

    task play_turn(input logic [6:0] h1, input logic [6:0] h2);
        exp_t e;
        exp_t got;
        int   settle_ok;
        bif.hp_player1 = h1;
        bif.hp_player2 = h2;
        drive_flag(1'b1);
        tick();
        total++;
        if (bif.state !== 3'd1) $display("FAIL throw_latency: got %0d want 1", bif.state);
        else passed++;
        tick();
        drive_flag(1'b0);
        total++;
        if (bif.state !== 3'd2 || bif.throw_enable !== 1'b0)
            $display("FAIL enter_flight: got state=%0d te=%0d want 2 0", bif.state, bif.throw_enable);
        else passed++;
        if (h1 == 7'd0 && h2 == 7'd0) e = '{st: 3'd5, turn: m_turn, winner: 2'b11};
        else if (h1 == 7'd0)          e = '{st: 3'd5, turn: m_turn, winner: 2'b10};
        else if (h2 == 7'd0)          e = '{st: 3'd5, turn: m_turn, winner: 2'b01};
        else                          e = '{st: 3'd1, turn: m_turn + 3'd1, winner: 2'b00};
        exp_q.push_back(e);
        bif.end_throw = 1'b1;
        tick();
        bif.end_throw = 1'b0;
        settle_ok = 1;
        for (int i = 0; i < S; i++) begin
            tick();
            if (bif.state !== 3'd3) settle_ok = 0;
        end
        total++;
        if (settle_ok != 1) $display("FAIL settle_len: state=%0d want 3 for %0d cycles", bif.state, S);
        else passed++;
        tick();
        total++;
        if (bif.state !== 3'd4) $display("FAIL check_phase: got %0d want 4", bif.state);
        else passed++;
        tick();
        got = '{st: bif.state, turn: bif.turn, winner: bif.winner};
        e = exp_q.pop_front();
        total++;
        if (got !== e || bif.turn_pulse !== (e.st == 3'd1) || bif.game_over !== (e.st == 3'd5) ||
            bif.throw_enable !== (e.st == 3'd1 && e.turn[0] == bif.current_player))
            $display("FAIL outcome: got st=%0d turn=%0d win=%0d tp=%0d go=%0d te=%0d want st=%0d turn=%0d win=%0d",
                     got.st, got.turn, got.winner, bif.turn_pulse, bif.game_over,
                     bif.throw_enable, e.st, e.turn, e.winner);
        else passed++;
        m_turn = e.turn;
        if (e.st == 3'd1) begin
            tick();
            total++;
            if (bif.turn_pulse !== 1'b0) $display("FAIL turn_pulse_width: got 1 want 0");
            else passed++;
        end
    endtask

    task test_aim_ignores();
        if (m_turn[0] == bif.current_player) bif.in_throw_flag = 1'b1;
        else bif.throw_flag = 1'b1;
        tick();
        bif.in_throw_flag = 1'b0;
        bif.throw_flag    = 1'b0;
        repeat (3) tick();
        total++;
        if (bif.state !== 3'd1) $display("FAIL wrong_flag_ignored: got %0d want 1", bif.state);
        else passed++;
        bif.end_throw = 1'b1;
        tick();
        bif.end_throw = 1'b0;
        bif.restart   = 1'b1;
        tick();
        bif.restart = 1'b0;
        repeat (3) tick();
        total++;
        if (bif.state !== 3'd1 || bif.turn !== m_turn)
            $display("FAIL end_restart_in_aim: got state=%0d turn=%0d want 1 %0d", bif.state, bif.turn, m_turn);
        else passed++;
    endtask

    task test_first_turn();
        play_turn(7'd50, 7'd50);
    endtask

    task test_turn_wrap();
        logic [2:0] start;
        start = m_turn;
        for (int i = 0; i < 8; i++) play_turn(7'd40, 7'd30);
        total++;
        if (bif.turn !== start) $display("FAIL turn_wrap: got %0d want %0d", bif.turn, start);
        else passed++;
    endtask

    task test_held_flag();
        int entries;
        logic [2:0] prev;
        if (m_turn[0] != bif.current_player) play_turn(7'd50, 7'd50);
        bif.hp_player1 = 7'd50;
        bif.hp_player2 = 7'd50;
        exp_q.push_back('{st: 3'd1, turn: m_turn + 3'd1, winner: 2'b00});
        bif.throw_flag = 1'b1;
        entries = 0;
        prev = bif.state;
        for (int i = 0; i < 100; i++) begin
            if (i == 2) bif.end_throw = 1'b1;
            if (i == 3) bif.end_throw = 1'b0;
            tick();
            if (bif.state == 3'd2 && prev != 3'd2) entries++;
            prev = bif.state;
        end
        bif.throw_flag = 1'b0;
        total++;
        if (entries != 1) $display("FAIL held_flag_entries: got %0d want 1", entries);
        else passed++;
        begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (bif.state !== e.st || bif.turn !== e.turn)
                $display("FAIL held_flag_state: got st=%0d turn=%0d want st=%0d turn=%0d",
                         bif.state, bif.turn, e.st, e.turn);
            else passed++;
            m_turn = e.turn;
        end
    endtask

    task do_restart();
        repeat (2) tick();
        total++;
        if (bif.state !== 3'd5 || bif.game_over !== 1'b1)
            $display("FAIL over_hold: got st=%0d go=%0d want 5 1", bif.state, bif.game_over);
        else passed++;
        bif.restart = 1'b1;
        tick();
        bif.restart = 1'b0;
        tick();
        total++;
        if (bif.state !== 3'd0 || bif.turn !== 3'd0 || bif.winner !== 2'b00 || bif.game_over !== 1'b0)
            $display("FAIL restart_idle: got st=%0d turn=%0d win=%0d go=%0d want 0 0 0 0",
                     bif.state, bif.turn, bif.winner, bif.game_over);
        else passed++;
        tick();
        m_turn = 3'd0;
        total++;
        if (bif.state !== 3'd1) $display("FAIL restart_aim: got %0d want 1", bif.state);
        else passed++;
    endtask

    task test_game_over();
        play_turn(7'd20, 7'd0);
        do_restart();
        play_turn(7'd0, 7'd0);
        do_restart();
        play_turn(7'd0, 7'd30);
        do_restart();
    endtask

    task test_reset_mid();
        drive_flag(1'b1);
        repeat (2) tick();
        drive_flag(1'b0);
        total++;
        if (bif.state !== 3'd2) $display("FAIL mid_reset_setup: got %0d want 2", bif.state);
        else passed++;
        rst = 1'b1;
        bif.end_throw = 1'b1;
        tick();
        rst = 1'b0;
        bif.end_throw = 1'b0;
        total++;
        if ({bif.state, bif.turn, bif.turn_pulse, bif.throw_enable, bif.game_over,
             bif.winner, bif.timeout_pulse} !== 13'd0)
            $display("FAIL mid_reset: got state=%0d turn=%0d te=%0d want all 0",
                     bif.state, bif.turn, bif.throw_enable);
        else passed++;
        repeat (2) tick();
        m_turn = 3'd0;
        total++;
        if (bif.state !== 3'd1) $display("FAIL mid_reset_rejoin: got %0d want 1", bif.state);
        else passed++;
    endtask

    task test_timeout();
        int early;
        early = 0;
`ifdef GAME_SEQUENCER_AIM_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bif.timeout_pulse !== 1'b0) early++;
        end
        total++;
        if (early != 0) $display("FAIL timeout_early: got %0d pulses want 0", early);
        else passed++;
        tick();
        total++;
        if (bif.timeout_pulse !== 1'b1 || bif.turn_pulse !== 1'b1 || bif.turn !== m_turn + 3'd1 ||
            bif.state !== 3'd1)
            $display("FAIL timeout_forfeit: got tp=%0d tup=%0d turn=%0d st=%0d want 1 1 %0d 1",
                     bif.timeout_pulse, bif.turn_pulse, bif.turn, bif.state, m_turn + 3'd1);
        else passed++;
        m_turn = m_turn + 3'd1;
        repeat (14) tick();
        drive_flag(1'b1);
        repeat (2) tick();
        drive_flag(1'b0);
        total++;
        if (bif.state !== 3'd2 || bif.timeout_pulse !== 1'b0 || bif.turn !== m_turn)
            $display("FAIL timeout_throw_wins: got st=%0d tp=%0d turn=%0d want 2 0 %0d",
                     bif.state, bif.timeout_pulse, bif.turn, m_turn);
        else passed++;
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bif.timeout_pulse !== 1'b0 || bif.state !== 3'd1) early++;
        end
        total++;
        if (early != 0) $display("FAIL no_timeout: got %0d bad cycles want 0", early);
        else passed++;
`endif
    endtask

    initial begin
        test_reset(1'b1);
        test_reset(1'b0);
        test_aim_ignores();
        test_first_turn();
        test_aim_ignores();
        test_turn_wrap();
        test_held_flag();
        test_game_over();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Turn and phase controller for the two-board cat-and-dog throwing game. It sits in the 60 MHz domain beside the choose-player and throw logic and owns the game flow: wait for both players, open the aiming window for whichever side owns the turn, track the projectile in flight, let hit points settle, then advance the turn or declare a winner. Its `turn` and `turn_pulse` outputs feed wind selection and speed setup. `throw_enable` gates the local throw logic.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles held in SETTLE after `end_throw` so the HP registers update before CHECK; legal range 1–255.
- `AIM_TIMEOUT_CYCLES`, default 600_000_000: length of the aiming window (10 s at 60 MHz); used only with `AIM_TIMEOUT_EN`.

Ports:
- `clk60MHz` in 1: system clock.
- `rst` in 1: reset; synchronous, active-high.
- `player1_ready` in 1: player 1 ready, combined local/remote level.
- `player2_ready` in 1: player 2 ready, combined local/remote level.
- `current_player` in 1: which player this board is; 0 = player 1, 1 = player 2.
- `throw_flag` in 1: local throw request level.
- `in_throw_flag` in 1: remote throw request level.
- `end_throw` in 1: projectile landed; single-cycle pulse or level.
- `hp_player1` in 7: player 1 hit points.
- `hp_player2` in 7: player 2 hit points.
- `restart` in 1: leave OVER and start a new game.
- `state` out 3: current phase; IDLE=0, AIM=1, FLIGHT=2, SETTLE=3, CHECK=4, OVER=5.
- `turn` out 3: turn counter; `turn[0]` is the active player (0 = player 1).
- `turn_pulse` out 1: one-cycle strobe when `turn` advances.
- `throw_enable` out 1: the local board may throw now.
- `game_over` out 1: high while in OVER.
- `winner` out 2: 00 none, 01 player 1, 10 player 2, 11 draw.
- `timeout_pulse` out 1: one-cycle strobe when the aiming window expires.

## Operation
- Reset values: `state`=IDLE, `turn`=0, and every other output 0. The SETTLE counter, timeout counter and edge-detect registers all clear on reset.
- Throw edge detection: `throw_flag` and `in_throw_flag` are each registered once. A rising edge means registered previous = 0 and current = 1.
- IDLE: when `player1_ready` and `player2_ready` are both sampled high, go to AIM.
- AIM:
  - `throw_enable` = (`turn[0]` == `current_player`).
  - Accepted edge is the `throw_flag` rise when the local player is active, or the `in_throw_flag` rise when the remote player is active. The opposite flag is ignored.
  - An accepted edge goes to FLIGHT. An `end_throw` seen in AIM is ignored.
- FLIGHT: `throw_enable`=0. When `end_throw` is high, go to SETTLE and load the counter with `SETTLE_CYCLES`-1.
- SETTLE: decrement the counter each cycle; go to CHECK when it reaches 0.
- CHECK lasts one cycle:
  - Both HP = 0: `winner`=11, go to OVER.
  - Only `hp_player1`=0: `winner`=10, go to OVER.
  - Only `hp_player2`=0: `winner`=01, go to OVER.
  - Otherwise: `turn` = `turn`+1 modulo 8 (7 wraps to 0), `turn_pulse`=1 for that cycle, go to AIM.
- OVER:
  - `game_over`=1 and `winner` is held.
  - `restart` high: go to IDLE, clear `turn` and `winner`.
  - `restart` high in any other state is ignored.
- After IDLE, ready levels are ignored; dropping `player1_ready` or `player2_ready` mid-game has no effect.
- When `rst` and any event occur in the same cycle, reset wins.

## Timing
- All outputs are registered; no input reaches an output combinationally.
- IDLE→AIM: `state`=AIM on the first edge after both ready inputs are sampled high.
- Throw latency: flag high at edge N sets the edge detector; `state`=FLIGHT and `throw_enable`=0 at edge N+1.
- `end_throw` sampled at edge M:
  - SETTLE occupies edges M+1 … M+`SETTLE_CYCLES`.
  - CHECK is at edge M+`SETTLE_CYCLES`+1.
  - AIM or OVER, together with `turn_pulse` or `winner`, at edge M+`SETTLE_CYCLES`+2.
- `turn_pulse` and the new `turn` value are visible in the same cycle.
- A flag held high across several cycles produces exactly one accepted throw. A flag already high on entry to AIM must fall and rise again to be accepted.

## Configuration
- `GAME_SEQUENCER_AIM_TIMEOUT_EN` defined:
  - A counter clears on every entry to AIM and increments each cycle in AIM.
  - On reaching `AIM_TIMEOUT_CYCLES`-1 with no accepted edge, the turn is forfeited: `timeout_pulse`=1, `turn`+1, `turn_pulse`=1, and the block stays in AIM with the counter cleared.
  - If an accepted edge arrives in the same cycle as the timeout, the throw wins and there is no forfeit.
- Macro undefined:
  - No timeout counter is built, `timeout_pulse` is tied to 0, and AIM waits indefinitely.

## Test plan
- Reset then both ready high at edge 5: `state`=AIM at edge 6, `turn`=0, and `throw_enable`=1 with `current_player`=0 (=0 with `current_player`=1).
- `current_player`=0, `turn`=0: `in_throw_flag` pulse → stays AIM. `throw_flag` rise at edge N → FLIGHT at N+1. `end_throw` at M with `SETTLE_CYCLES`=4 → AIM, `turn`=1 and `turn_pulse` at M+6.
- `hp_player2`=0 at CHECK → OVER, `winner`=01, `game_over`=1. `restart` → IDLE with `turn`=0 and `winner`=00. With both HP=0 → `winner`=11.
- Eight full turns: `turn` wraps 7→0 with `turn_pulse` on each advance. `throw_flag` held high for 100 cycles → exactly one FLIGHT entry.
- `rst` asserted mid-FLIGHT → next edge `state`=IDLE and all outputs 0. `end_throw` in AIM → ignored.
- With the macro and `AIM_TIMEOUT_CYCLES`=16: no throw → `timeout_pulse` at the 16th AIM cycle and `turn`+1. Throw on that exact cycle → FLIGHT, no `timeout_pulse`.
